// File: rtl/mem_map_pkg.sv
// Shared address map for the data-port responder: MMIO page default base,
// register offsets within the page, STATUS bit positions, and helpers to
// decode a word offset and to assemble the STATUS word.
package mem_map_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

  // Byte offsets inside the 4 KiB MMIO page
  localparam logic [11:0] OFF_DBG_OUT = 12'h000;
  localparam logic [11:0] OFF_STATUS  = 12'h004;
  localparam logic [11:0] OFF_CYC_LO  = 12'h008;
  localparam logic [11:0] OFF_CYC_HI  = 12'h00C;
  localparam logic [11:0] OFF_TOHOST  = 12'h010;

  // STATUS layout: {16'b0, count[7:0], 5'b0, ovf, full, empty}
  localparam int unsigned STATUS_EMPTY_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_OVF_BIT   = 2;
  localparam int unsigned STATUS_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_DBG_OUT,
    REG_STATUS,
    REG_CYC_LO,
    REG_CYC_HI,
    REG_TOHOST
  } mmio_reg_e;

  // word_off is addr[11:2]; byte lanes are ignored
  function automatic mmio_reg_e decode_reg(input logic [9:0] word_off);
    case ({word_off, 2'b00})
      OFF_DBG_OUT: return REG_DBG_OUT;
      OFF_STATUS:  return REG_STATUS;
      OFF_CYC_LO:  return REG_CYC_LO;
      OFF_CYC_HI:  return REG_CYC_HI;
      OFF_TOHOST:  return REG_TOHOST;
      default:     return REG_NONE;
    endcase
  endfunction

  function automatic logic [31:0] status_word(input logic [7:0] count,
                                              input logic       ovf,
                                              input logic       full,
                                              input logic       empty);
    logic [31:0] s;
    s = '0;
    s[STATUS_COUNT_LSB +: 8] = count;
    s[STATUS_OVF_BIT]        = ovf;
    s[STATUS_FULL_BIT]       = full;
    s[STATUS_EMPTY_BIT]      = empty;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO used for the debug character stream.
//   clk, rst_n     : clock / asynchronous active-low reset (discards contents)
//   push, push_data: write request and data
//   pop            : consumer ready; a pop happens only when non-empty
//   rd_data        : head entry, zero while empty
//   full, empty    : occupancy flags
//   count          : number of stored entries (0..DEPTH)
//   overflow       : one-cycle pulse when a push is dropped
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  // When empty a simultaneous push wins and nothing is popped
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & full & ~do_pop;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder for the pipelined core: word RAM at address 0 plus an
// MMIO page holding a debug character FIFO, a 64-bit cycle counter, a status
// word and a TOHOST halt register. Reads are combinational and side-effect
// free; writes take effect on the rising edge.
//   clk, reset        : clock / asynchronous active-low reset
//   arith_result_m    : byte address from the M stage
//   store_data_m      : lane-aligned store data
//   mem_write_m       : one-cycle write strobe
//   read_data_m       : combinational read data
//   dbg_data/valid    : debug FIFO head and non-empty flag
//   dbg_ready         : consumer accepts head when dbg_valid & dbg_ready
//   halt, exit_code   : sticky halt and value written to TOHOST
module data_mem_responder
  import mem_map_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] arith_result_m,
  input  logic [31:0] store_data_m,
  input  logic        mem_write_m,
  output logic [31:0] read_data_m,
  output logic [7:0]  dbg_data,
  output logic        dbg_valid,
  input  logic        dbg_ready,
  output logic        halt,
  output logic [31:0] exit_code
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram [RAM_WORDS];
  logic          ram_hit;
  logic          mmio_hit;
  logic [AW-1:0] ram_idx;
  mmio_reg_e     reg_sel;
  logic          wr_dbg;
  logic          wr_status;
  logic          wr_tohost;
  logic [63:0]   cycle_cnt;
  logic          ovf;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_overflow;
  logic [CW-1:0] fifo_count;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^arith_result_m[1:0];

  assign ram_hit  = (arith_result_m[31:AW+2] == '0);
  assign ram_idx  = arith_result_m[AW+1:2];
  assign mmio_hit = (arith_result_m[31:12] == MMIO_BASE[31:12]);
  assign reg_sel  = mmio_hit ? decode_reg(arith_result_m[11:2]) : REG_NONE;

  assign wr_dbg    = mem_write_m & (reg_sel == REG_DBG_OUT);
  assign wr_status = mem_write_m & (reg_sel == REG_STATUS);
  assign wr_tohost = mem_write_m & (reg_sel == REG_TOHOST);

  always_ff @(posedge clk) begin
    if (mem_write_m && ram_hit) ram[ram_idx] <= store_data_m;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_dbg_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (wr_dbg),
    .push_data (store_data_m[7:0]),
    .pop       (dbg_ready),
    .rd_data   (dbg_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (fifo_overflow)
  );

  assign dbg_valid = ~fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
      ovf       <= 1'b0;
      halt      <= 1'b0;
      exit_code <= '0;
    end else begin
      if (!halt) cycle_cnt <= cycle_cnt + 64'd1;
      // Overflow and STATUS write cannot coincide: one address per cycle
      if (fifo_overflow)  ovf <= 1'b1;
      else if (wr_status) ovf <= 1'b0;
      if (wr_tohost && !halt) begin
        halt      <= 1'b1;
        exit_code <= store_data_m;
      end
    end
  end

  always_comb begin
    read_data_m = '0;
    if (ram_hit) begin
      read_data_m = ram[ram_idx];
    end else begin
      case (reg_sel)
        REG_STATUS: read_data_m = status_word(8'(fifo_count), ovf, fifo_full, fifo_empty);
        REG_CYC_LO: read_data_m = cycle_cnt[31:0];
        REG_CYC_HI: read_data_m = cycle_cnt[63:32];
        REG_TOHOST: read_data_m = exit_code;
        default:    read_data_m = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int          D  = 8;
  localparam int          RW = 1024;
  localparam logic [31:0] MB = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] arith_result_m = '0;
  logic [31:0] store_data_m = '0;
  logic        mem_write_m = 1'b0;
  logic [31:0] read_data_m;
  logic [7:0]  dbg_data;
  logic        dbg_valid;
  logic        dbg_ready = 1'b0;
  logic        halt;
  logic [31:0] exit_code;

  always #5 clk = ~clk;

  data_mem_responder #(
    .RAM_WORDS  (RW),
    .FIFO_DEPTH (D),
    .MMIO_BASE  (MB),
    .INIT_FILE  ("")
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .arith_result_m (arith_result_m),
    .store_data_m   (store_data_m),
    .mem_write_m    (mem_write_m),
    .read_data_m    (read_data_m),
    .dbg_data       (dbg_data),
    .dbg_valid      (dbg_valid),
    .dbg_ready      (dbg_ready),
    .halt           (halt),
    .exit_code      (exit_code)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
    bit          chk;
  } rd_exp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          done = 1'b0;
  rd_exp_t     rd_q[$];
  logic [7:0]  dbg_q[$];
  bit          pop_pending = 1'b0;
  bit          ovf_m = 1'b0;
  bit          halt_m = 1'b0;
  logic [31:0] exit_m = '0;
  logic [63:0] cyc_m = '0;
  logic [31:0] ram_m [int unsigned];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit in_ram(input logic [31:0] a);
    return a < 32'(RW * 4);
  endfunction

  function automatic bit in_mmio(input logic [31:0] a);
    return (a >= MB) && (a - MB < 32'h1000);
  endfunction

  function automatic logic [31:0] mmio_off(input logic [31:0] a);
    return (a - MB) & 32'h0000_0FFC;
  endfunction

  // Reference read value derived from the register map and model state
  function automatic logic [31:0] exp_read(input logic [31:0] a, output bit known);
    int n;
    known = 1'b1;
    n = dbg_q.size();
    if (in_ram(a)) begin
      if (ram_m.exists(a >> 2)) return ram_m[a >> 2];
      known = 1'b0;
      return '0;
    end
    if (!in_mmio(a)) return '0;
    case (mmio_off(a))
      32'h4:   return 32'(n * 256 + (ovf_m ? 4 : 0) + (n == D ? 2 : 0) + (n == 0 ? 1 : 0));
      32'h8:   return cyc_m[31:0];
      32'hC:   return cyc_m[63:32];
      32'h10:  return exit_m;
      default: return '0;
    endcase
  endfunction

  // Reference model state update at each clock edge while out of reset
  always @(posedge clk) begin
    if (reset) begin
      int  occ;
      bit  popped;
      popped      = pop_pending;
      pop_pending = 1'b0;
      occ         = dbg_q.size() + (popped ? 1 : 0);
      if (!halt_m) cyc_m = cyc_m + 64'd1;
      if (mem_write_m) begin
        if (in_ram(arith_result_m)) begin
          ram_m[arith_result_m >> 2] = store_data_m;
        end else if (in_mmio(arith_result_m)) begin
          case (mmio_off(arith_result_m))
            32'h0: begin
              if (occ < D || popped) dbg_q.push_back(store_data_m[7:0]);
              else ovf_m = 1'b1;
            end
            32'h4: ovf_m = 1'b0;
            32'h10: begin
              if (!halt_m) begin
                halt_m = 1'b1;
                exit_m = store_data_m;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Monitor: pops expected read data every cycle, checks the debug stream
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset && !done) begin
        rd_exp_t    e;
        logic [7:0] head;
        if (rd_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL read_queue: got empty, expected a pending read");
        end else begin
          e = rd_q.pop_front();
          if (e.chk) check($sformatf("read_data_m@%08h", e.addr), 64'(read_data_m), 64'(e.exp));
        end
        check("dbg_valid", 64'(dbg_valid), 64'(dbg_q.size() != 0));
        if (dbg_q.size() != 0) begin
          check("dbg_data", 64'(dbg_data), 64'(dbg_q[0]));
          if (dbg_ready) begin
            head = dbg_q.pop_front();
            pop_pending = 1'b1;
          end
        end
        check("halt", 64'(halt), 64'(halt_m));
        check("exit_code", 64'(exit_code), 64'(exit_m));
      end
    end
  end

  // Driver: one bus cycle, expectation queued for the monitor
  task automatic cycle(input logic [31:0] a, input logic [31:0] d, input bit w, input bit r);
    rd_exp_t e;
    bit      k;
    @(negedge clk);
    arith_result_m = a;
    store_data_m   = d;
    mem_write_m    = w;
    dbg_ready      = r;
    e.addr = a;
    e.exp  = exp_read(a, k);
    e.chk  = k;
    rd_q.push_back(e);
  endtask

  task automatic rand_cycle(input bit allow_tohost, input int ready_pct);
    int          op;
    bit          r;
    logic [31:0] a;
    op = int'($urandom_range(0, 11));
    r  = (int'($urandom_range(0, 99)) < ready_pct);
    case (op)
      0, 1: begin
        a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
        cycle(a, $urandom, 1'b1, r);
      end
      2, 3: begin
        a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
        cycle(a, $urandom, 1'b0, r);
      end
      4, 5: cycle(MB | $urandom_range(0, 3), $urandom, 1'b1, r);
      6:    cycle(MB + 32'h4, 0, 1'b0, r);
      7:    cycle(MB + 32'h4, $urandom, ($urandom_range(0, 3) == 0), r);
      8:    cycle(MB + ($urandom_range(0, 1) ? 32'h8 : 32'hC), $urandom, 1'b0, r);
      9: begin
        a = 32'h1000 + $urandom_range(0, 32'h6FFF_FFFF);
        cycle(a, $urandom, 1'(($urandom_range(0, 1))), r);
      end
      10: begin
        a = ($urandom_range(0, 3) == 0) ? MB : MB + ($urandom_range(5, 1023) << 2);
        cycle(a, $urandom, ($urandom_range(0, 1) == 1) && (a != MB), r);
      end
      default: cycle(MB + 32'h10, $urandom, allow_tohost && ($urandom_range(0, 7) == 0), r);
    endcase
  endtask

  initial begin
    // Reset state
    #1 reset = 1'b0;
    #1;
    check("reset dbg_valid", 64'(dbg_valid), 64'd0);
    check("reset dbg_data", 64'(dbg_data), 64'd0);
    check("reset halt", 64'(halt), 64'd0);
    check("reset exit_code", 64'(exit_code), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // RAM write / read-back / byte-offset alias / out of range
    cycle(32'h0000_0040, 32'hDEAD_BEEF, 1'b1, 1'b0);
    cycle(32'h0000_0040, 32'h0, 1'b0, 1'b0);
    cycle(32'h0000_0041, 32'h0, 1'b0, 1'b0);
    cycle(32'h0000_4000, 32'h0, 1'b0, 1'b0);

    // Three bytes queued, then drained
    cycle(MB, 32'h41, 1'b1, 1'b0);
    cycle(MB, 32'h42, 1'b1, 1'b0);
    cycle(MB, 32'h43, 1'b1, 1'b0);
    cycle(MB + 32'h4, 32'h0, 1'b0, 1'b0);
    repeat (5) cycle(MB + 32'h4, 32'h0, 1'b0, 1'b1);

    // Overflow, clear, then full with simultaneous push and pop
    for (int i = 0; i < 9; i++) cycle(MB, 32'h60 + 32'(i), 1'b1, 1'b0);
    cycle(MB + 32'h4, 32'h0, 1'b0, 1'b0);
    cycle(MB + 32'h4, 32'hFFFF_FFFF, 1'b1, 1'b0);
    cycle(MB + 32'h4, 32'h0, 1'b0, 1'b0);
    cycle(MB, 32'h5A, 1'b1, 1'b1);
    repeat (10) cycle(MB + 32'h4, 32'h0, 1'b0, 1'b1);

    // Random traffic, slow and fast consumers
    repeat (200) rand_cycle(1'b0, 5);
    repeat (300) rand_cycle(1'b0, 60);

    // Counter, then halt via TOHOST; a second TOHOST write is ignored
    repeat (100) cycle(MB + 32'h8, 32'h0, 1'b0, 1'b1);
    cycle(MB + 32'h10, 32'h1, 1'b1, 1'b1);
    repeat (3) cycle(MB + 32'h8, 32'h0, 1'b0, 1'b1);
    cycle(MB + 32'h10, 32'h2, 1'b1, 1'b1);
    cycle(MB + 32'h10, 32'h0, 1'b0, 1'b1);
    repeat (150) rand_cycle(1'b1, 40);

    // Asynchronous reset with bytes queued while halted
    cycle(MB, 32'h31, 1'b1, 1'b0);
    cycle(MB, 32'h32, 1'b1, 1'b0);
    cycle(MB, 32'h33, 1'b1, 1'b0);
    cycle(MB + 32'h4, 32'h0, 1'b0, 1'b0);
    #3;
    reset = 1'b0;
    mem_write_m = 1'b0;
    #1;
    check("async dbg_valid", 64'(dbg_valid), 64'd0);
    check("async halt", 64'(halt), 64'd0);
    check("async exit_code", 64'(exit_code), 64'd0);
    dbg_q.delete();
    pop_pending = 1'b0;
    ovf_m  = 1'b0;
    halt_m = 1'b0;
    exit_m = '0;
    cyc_m  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    cycle(MB + 32'h8, 32'h0, 1'b0, 1'b0);
    cycle(MB + 32'h4, 32'h0, 1'b0, 1'b0);
    cycle(MB + 32'h8, 32'h0, 1'b0, 1'b0);

    // More random traffic, TOHOST allowed, then drain
    repeat (300) rand_cycle(1'b1, 50);
    repeat (12) cycle(MB + 32'h4, 32'h0, 1'b0, 1'b1);
    check("final fifo drained", 64'(dbg_q.size()), 64'd0);

    #3 done = 1'b1;
    #20;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
